fft_addr_ctrl: RTL and testbench

// Status/address responder to the FFT master control FSM. Consumes its strobes (addr_mode,

---
 rtl/fft_addr_ctrl_if.sv | 41 ++++
 rtl/fft_addr_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fft_addr_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_addr_ctrl_if.sv
// rtl/fft_addr_ctrl_if.sv - strobe/status bundle between FFT master FSM and address controller
// Purpose: groups the master FSM strobes and the address/progress status returned to it.
// Ports (signals):
//   strobes (master -> slave): fft_start, addr_mode[1:0], shift_in_ena, sram_write_ena,
//                              k_ena, k_clear, iteration_ena
//   status  (slave -> master): sram_addr[ADDR_W-1:0], samples_loaded_count[2:0],
//                              samples_loaded_done, samples_in_done, samples_written_done,
//                              samples_out_done, iteration_done, fft_done, stage[2:0]
interface fft_addr_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              fft_start;
    logic [1:0]        addr_mode;
    logic              shift_in_ena;
    logic              sram_write_ena;
    logic              k_ena;
    logic              k_clear;
    logic              iteration_ena;

    logic [ADDR_W-1:0] sram_addr;
    logic [2:0]        samples_loaded_count;
    logic              samples_loaded_done;
    logic              samples_in_done;
    logic              samples_written_done;
    logic              samples_out_done;
    logic              iteration_done;
    logic              fft_done;
    logic [2:0]        stage;

    modport master (
        output fft_start, addr_mode, shift_in_ena, sram_write_ena, k_ena, k_clear, iteration_ena,
        input  sram_addr, samples_loaded_count, samples_loaded_done, samples_in_done,
               samples_written_done, samples_out_done, iteration_done, fft_done, stage
    );

    modport slave (
        input  fft_start, addr_mode, shift_in_ena, sram_write_ena, k_ena, k_clear, iteration_ena,
        output sram_addr, samples_loaded_count, samples_loaded_done, samples_in_done,
               samples_written_done, samples_out_done, iteration_done, fft_done, stage
    );
endinterface

// File: rtl/fft_addr_ctrl.sv
// rtl/fft_addr_ctrl.sv - SRAM address generator and progress flags for in-place radix-2 DIT FFT
// Purpose: tracks stage s, butterfly b and twiddle index k for the FFT master FSM and drives
//          a registered SRAM address for the A/B data reads, twiddle read and A/B writes.
// Ports:
//   clk    in  rising-edge clock
//   n_rst  in  asynchronous active-low reset
//   bus    fft_addr_ctrl_if.slave: strobes in, sram_addr and progress flags out
module fft_addr_ctrl #(
    parameter int LOG2N     = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_BASE = 0,
    parameter int TWID_BASE = 1024
) (
    input  logic               clk,
    input  logic               n_rst,
    fft_addr_ctrl_if.slave     bus
);
    localparam int         BW     = LOG2N - 1;
    localparam logic [2:0] S_LAST = 3'(LOG2N - 1);

    logic [BW-1:0]     b_q, b_d;
    logic [BW-1:0]     k_q, k_d;
    logic [2:0]        s_q, s_d;
    logic              busy_q, busy_d;
    logic              in_ptr_q, in_ptr_d;
    logic              out_ptr_q, out_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              wr_done_q, wr_done_d;
    logic              out_done_q, out_done_d;
    logic              it_done_q, it_done_d;
    logic              fft_done_q, fft_done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Butterfly operand indices: A is b with a zero bit inserted at position s,
    // B is A with that bit set. The twiddle exponent is pos scaled to the N-point table.
    logic [LOG2N-1:0]  b_ext, span, pos, a_idx, b_idx, k_wide;
    logic [BW-1:0]     k_next;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_w;

    always_comb begin
        b_ext  = {1'b0, b_q};
        span   = LOG2N'(1) << s_q;
        pos    = b_ext & (span - LOG2N'(1));
        a_idx  = ((b_ext >> s_q) << (s_q + 3'd1)) | pos;
        b_idx  = a_idx | span;
        k_wide = pos << (S_LAST - s_q);
        k_next = k_wide[BW-1:0];
        addr_a = ADDR_W'(DATA_BASE) + ADDR_W'(a_idx);
        addr_b = ADDR_W'(DATA_BASE) + ADDR_W'(b_idx);
        addr_w = ADDR_W'(TWID_BASE) + ADDR_W'(k_q);
    end

    always_comb begin
        b_d        = b_q;
        k_d        = k_q;
        s_d        = s_q;
        busy_d     = busy_q;
        in_ptr_d   = in_ptr_q;
        out_ptr_d  = out_ptr_q;
        cnt_d      = cnt_q;
        wr_done_d  = 1'b0;
        out_done_d = out_done_q;
        it_done_d  = 1'b0;
        fft_done_d = fft_done_q;
        addr_d     = addr_q;

        if (bus.fft_start) begin
            // Restart wins over every other strobe in the same cycle.
            b_d        = '0;
            k_d        = '0;
            s_d        = '0;
            busy_d     = 1'b1;
            in_ptr_d   = 1'b0;
            out_ptr_d  = 1'b0;
            cnt_d      = '0;
            out_done_d = 1'b0;
            fft_done_d = 1'b0;
        end else begin
            unique case (bus.addr_mode)
                2'b01:   addr_d = in_ptr_q  ? addr_b : addr_a;
                2'b10:   addr_d = addr_w;
                2'b11:   addr_d = out_ptr_q ? addr_b : addr_a;
                default: addr_d = addr_q;
            endcase

            if (bus.shift_in_ena && bus.addr_mode == 2'b01)
                in_ptr_d = 1'b1;
            if (bus.shift_in_ena && cnt_q != 2'd3)
                cnt_d = cnt_q + 2'd1;

            // Once both results are written, further writes for this butterfly are dropped.
            if (bus.sram_write_ena && !out_done_q) begin
                out_ptr_d = ~out_ptr_q;
                if (out_ptr_q) begin
                    wr_done_d  = 1'b1;
                    out_done_d = 1'b1;
                end
            end

            if (bus.k_clear)
                k_d = '0;
            else if (bus.k_ena)
                k_d = k_next;

            if (bus.iteration_ena && busy_q) begin
                in_ptr_d   = 1'b0;
                out_ptr_d  = 1'b0;
                cnt_d      = '0;
                out_done_d = 1'b0;
                if (&b_q) begin
                    b_d       = '0;
                    it_done_d = 1'b1;
                    if (s_q == S_LAST) begin
                        s_d        = '0;
                        fft_done_d = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        s_d = s_q + 3'd1;
                    end
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            b_q        <= '0;
            k_q        <= '0;
            s_q        <= '0;
            busy_q     <= 1'b0;
            in_ptr_q   <= 1'b0;
            out_ptr_q  <= 1'b0;
            cnt_q      <= '0;
            wr_done_q  <= 1'b0;
            out_done_q <= 1'b0;
            it_done_q  <= 1'b0;
            fft_done_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            b_q        <= b_d;
            k_q        <= k_d;
            s_q        <= s_d;
            busy_q     <= busy_d;
            in_ptr_q   <= in_ptr_d;
            out_ptr_q  <= out_ptr_d;
            cnt_q      <= cnt_d;
            wr_done_q  <= wr_done_d;
            out_done_q <= out_done_d;
            it_done_q  <= it_done_d;
            fft_done_q <= fft_done_d;
            addr_q     <= addr_d;
        end
    end

    assign bus.sram_addr            = addr_q;
    assign bus.samples_loaded_count = {1'b0, cnt_q};
    assign bus.samples_loaded_done  = (cnt_q == 2'd3);
    assign bus.samples_in_done      = (cnt_q == 2'd3);
    assign bus.samples_written_done = wr_done_q;
    assign bus.samples_out_done     = out_done_q;
    assign bus.iteration_done       = it_done_q;
    assign bus.fft_done             = fft_done_q;
    assign bus.stage                = s_q;
endmodule

// File: tb/tb_fft_addr_ctrl.sv
// tb/tb_fft_addr_ctrl.sv - directed scoreboard bench for fft_addr_ctrl (LOG2N=3)
module tb_fft_addr_ctrl;
    localparam int LOG2N = 3;
    localparam int TWID  = 1024;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    fft_addr_ctrl_if #(.ADDR_W(16)) bus ();

    fft_addr_ctrl #(
        .LOG2N(LOG2N), .ADDR_W(16), .DATA_BASE(0), .TWID_BASE(TWID)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    int m_s = 0, m_b = 0, m_busy = 0, m_fdone = 0;

    function automatic int addr_a(input int s, input int b);
        int span = 1 << s;
        return (b / span) * 2 * span + (b % span);
    endfunction

    function automatic int addr_b(input int s, input int b);
        return addr_a(s, b) + (1 << s);
    endfunction

    function automatic int k_of(input int s, input int b);
        return (b % (1 << s)) << (LOG2N - 1 - s);
    endfunction

    task automatic expect_val(input string tag, input int val);
        tag_q.push_back(tag);
        exp_q.push_back(32'(val));
    endtask

    task automatic chk(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        bus.fft_start      = 1'b0;
        bus.addr_mode      = 2'b00;
        bus.shift_in_ena   = 1'b0;
        bus.sram_write_ena = 1'b0;
        bus.k_ena          = 1'b0;
        bus.k_clear        = 1'b0;
        bus.iteration_ena  = 1'b0;
    endtask

    // fft_start with stray same-cycle strobes that must all be ignored.
    task automatic start();
        bus.fft_start      = 1'b1;
        bus.shift_in_ena   = 1'b1;
        bus.sram_write_ena = 1'b1;
        bus.iteration_ena  = 1'b1;
        m_s = 0; m_b = 0; m_busy = 1; m_fdone = 0;
        expect_val("start_stage", 0);
        expect_val("start_count", 0);
        expect_val("start_fft_done", 0);
        expect_val("start_out_done", 0);
        tick();
        clear_strobes();
        chk(32'(bus.stage));
        chk(32'(bus.samples_loaded_count));
        chk(32'(bus.fft_done));
        chk(32'(bus.samples_out_done));
    endtask

    task automatic iterate(input int n);
        int it;
        for (int i = 0; i < n; i++) begin
            bus.iteration_ena = 1'b1;
            it = 0;
            if (m_busy != 0) begin
                if (m_b == (1 << (LOG2N - 1)) - 1) begin
                    m_b = 0;
                    it  = 1;
                    if (m_s == LOG2N - 1) begin
                        m_s = 0; m_fdone = 1; m_busy = 0;
                    end else begin
                        m_s++;
                    end
                end else begin
                    m_b++;
                end
            end
            expect_val("iter_done", it);
            expect_val("iter_stage", m_s);
            expect_val("iter_fft_done", m_fdone);
            expect_val("iter_count_clr", 0);
            tick();
            bus.iteration_ena = 1'b0;
            chk(32'(bus.iteration_done));
            chk(32'(bus.stage));
            chk(32'(bus.fft_done));
            chk(32'(bus.samples_loaded_count));
        end
    endtask

    initial begin
        clear_strobes();
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;

        // Reset values
        expect_val("rst_addr", 0);
        expect_val("rst_count", 0);
        expect_val("rst_stage", 0);
        expect_val("rst_fft_done", 0);
        expect_val("rst_iter_done", 0);
        tick();
        chk(32'(bus.sram_addr));
        chk(32'(bus.samples_loaded_count));
        chk(32'(bus.stage));
        chk(32'(bus.fft_done));
        chk(32'(bus.iteration_done));

        // s=0 b=2: reads 4,5; twiddle 1024
        start();
        iterate(2);
        bus.addr_mode = 2'b01; bus.shift_in_ena = 1'b1;
        expect_val("s0_rd_a", addr_a(m_s, m_b));
        expect_val("s0_count1", 1);
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));
        chk(32'(bus.samples_loaded_count));
        bus.addr_mode = 2'b01;
        expect_val("s0_rd_b", addr_b(m_s, m_b));
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));
        bus.k_ena = 1'b1;
        expect_val("s0_hold", addr_b(m_s, m_b));
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));
        bus.addr_mode = 2'b10;
        expect_val("s0_twid", TWID + k_of(m_s, m_b));
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));

        // s=1 b=1: reads 1,3; twiddle 1026; saturation; writes 1,3; third write ignored
        iterate(3);
        bus.addr_mode = 2'b01; bus.shift_in_ena = 1'b1;
        expect_val("s1_rd_a", addr_a(m_s, m_b));
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));
        bus.addr_mode = 2'b01; bus.shift_in_ena = 1'b1; bus.k_ena = 1'b1;
        expect_val("s1_rd_b", addr_b(m_s, m_b));
        expect_val("s1_loaded_done_at2", 0);
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));
        chk(32'(bus.samples_loaded_done));
        bus.addr_mode = 2'b10; bus.shift_in_ena = 1'b1;
        expect_val("s1_twid", TWID + k_of(m_s, m_b));
        expect_val("s1_count3", 3);
        expect_val("s1_loaded_done", 1);
        expect_val("s1_in_done", 1);
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));
        chk(32'(bus.samples_loaded_count));
        chk(32'(bus.samples_loaded_done));
        chk(32'(bus.samples_in_done));
        bus.shift_in_ena = 1'b1;
        expect_val("s1_count_sat", 3);
        tick(); clear_strobes();
        chk(32'(bus.samples_loaded_count));
        bus.addr_mode = 2'b11; bus.sram_write_ena = 1'b1;
        expect_val("s1_wr_a", addr_a(m_s, m_b));
        expect_val("s1_wr_done_1st", 0);
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));
        chk(32'(bus.samples_written_done));
        bus.addr_mode = 2'b11; bus.sram_write_ena = 1'b1;
        expect_val("s1_wr_b", addr_b(m_s, m_b));
        expect_val("s1_wr_done_pulse", 1);
        expect_val("s1_out_done", 1);
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));
        chk(32'(bus.samples_written_done));
        chk(32'(bus.samples_out_done));
        expect_val("s1_wr_done_end", 0);
        expect_val("s1_out_done_held", 1);
        tick();
        chk(32'(bus.samples_written_done));
        chk(32'(bus.samples_out_done));
        bus.addr_mode = 2'b11; bus.sram_write_ena = 1'b1;
        expect_val("s1_wr3_addr", addr_a(m_s, m_b));
        expect_val("s1_wr3_no_pulse", 0);
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));
        chk(32'(bus.samples_written_done));
        bus.addr_mode = 2'b11;
        expect_val("s1_wr3_ptr_kept", addr_a(m_s, m_b));
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));

        // s=2 b=3: reads 3,7; twiddle 1027; k_clear beats k_ena
        iterate(6);
        expect_val("s2_out_done_clr", 0);
        chk(32'(bus.samples_out_done));
        bus.addr_mode = 2'b01; bus.shift_in_ena = 1'b1;
        expect_val("s2_rd_a", addr_a(m_s, m_b));
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));
        bus.addr_mode = 2'b01; bus.k_ena = 1'b1;
        expect_val("s2_rd_b", addr_b(m_s, m_b));
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));
        bus.addr_mode = 2'b10;
        expect_val("s2_twid", TWID + k_of(m_s, m_b));
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));
        bus.k_clear = 1'b1; bus.k_ena = 1'b1;
        tick(); clear_strobes();
        bus.addr_mode = 2'b10;
        expect_val("s2_kclear_twid", TWID);
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));

        // Full run: pulses at 4th, 8th, 12th iteration; extra strobes ignored when idle
        start();
        iterate(12);
        iterate(2);

        // Restart mid stage 1
        start();
        iterate(5);
        start();
        bus.addr_mode = 2'b01;
        expect_val("restart_rd_a", addr_a(0, 0));
        tick(); clear_strobes();
        chk(32'(bus.sram_addr));

        // Asynchronous reset mid-run, no clock edge between assertion and check
        iterate(5);
        bus.addr_mode = 2'b11; bus.sram_write_ena = 1'b1; bus.shift_in_ena = 1'b1;
        tick();
        tick(); clear_strobes();
        expect_val("pre_rst_out_done", 1);
        chk(32'(bus.samples_out_done));
        n_rst = 1'b0;
        #1;
        expect_val("arst_addr", 0);
        expect_val("arst_count", 0);
        expect_val("arst_stage", 0);
        expect_val("arst_out_done", 0);
        expect_val("arst_fft_done", 0);
        chk(32'(bus.sram_addr));
        chk(32'(bus.samples_loaded_count));
        chk(32'(bus.stage));
        chk(32'(bus.samples_out_done));
        chk(32'(bus.fft_done));
        #10;
        n_rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
